// File: rtl/acc_seq_pkg.sv
// Shared types and latency constants for the accumulator sequencing controller.
package acc_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        READ  = 2'd3
    } acc_state_e;

    localparam int unsigned ACC_WR_LAT = 4;
    localparam int unsigned ACC_RD_LAT = 2;
    localparam int unsigned SKID_DEPTH = 4;

endpackage

// File: rtl/acc_seq_skid.sv
// Small synchronous FIFO that absorbs accumulator read data when the result stream stalls.
module acc_seq_skid #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             empty
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/acc_seq_ctrl.sv
// Sequences multi-pass partial-sum accumulation into an accumulator RAM, then streams the totals out.
module acc_seq_ctrl
    import acc_seq_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned PASS_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] cfg_base,
    input  logic [ADDR_WIDTH-1:0] cfg_len_m1,
    input  logic [PASS_WIDTH-1:0] cfg_pass_m1,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  acc_wr_en,
    output logic                  acc_wr_we,
    output logic [ADDR_WIDTH-1:0] acc_wr_addr,
    output logic [DATA_WIDTH-1:0] acc_wr_wdata,
    output logic                  acc_mode,
    output logic                  acc_rd_en,
    output logic [ADDR_WIDTH-1:0] acc_rd_addr,
    input  logic [DATA_WIDTH-1:0] acc_rd_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy,
    output logic                  done
);
    localparam int unsigned DRAIN_W = $clog2(ACC_WR_LAT);
    localparam int unsigned RD_PIPE = ACC_RD_LAT - 1;
    localparam int unsigned CNT_W   = $clog2(SKID_DEPTH + 1);

    acc_state_e state, state_nxt;

    logic [ADDR_WIDTH-1:0] base_q, len_q, idx_q, ridx_q, oidx_q;
    logic [PASS_WIDTH-1:0] pass_m1_q, pass_q;
    logic [DRAIN_W-1:0]    drain_q;
    logic                  rd_done_q;
    logic [RD_PIPE-1:0]    rd_pipe_q;

    logic [CNT_W-1:0]      skid_count;
    logic                  skid_empty;
    logic [DATA_WIDTH-1:0] skid_head;
    logic [CNT_W:0]        occupancy;
    logic                  wr_fire, last_word, rd_fire, out_fire, last_out;

    assign in_ready  = (state == FILL);
    assign wr_fire   = in_ready && in_valid;
    assign last_word = (idx_q == len_q) && (pass_q == pass_m1_q);

    // Reads in flight plus buffered words must never exceed the skid depth.
    assign occupancy = (CNT_W + 1)'($countones(rd_pipe_q)) + (CNT_W + 1)'(skid_count);
    assign rd_fire   = (state == READ) && !rd_done_q && (occupancy < (CNT_W + 1)'(SKID_DEPTH));

    assign out_valid = !skid_empty;
    assign out_fire  = out_valid && out_ready;
    assign last_out  = (state == READ) && out_fire && (oidx_q == len_q);

    assign acc_wr_en    = wr_fire;
    assign acc_wr_we    = wr_fire;
    assign acc_wr_addr  = wr_fire ? base_q + idx_q : '0;
    assign acc_wr_wdata = wr_fire ? in_data : '0;
    assign acc_mode     = wr_fire && (pass_q != '0);
    assign acc_rd_en    = rd_fire;
    assign acc_rd_addr  = rd_fire ? base_q + ridx_q : '0;
    assign out_data     = out_valid ? skid_head : '0;
    assign busy         = (state != IDLE);
    assign done         = last_out;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = FILL;
            FILL:    if (wr_fire && last_word) state_nxt = DRAIN;
            DRAIN:   if (drain_q == DRAIN_W'(ACC_WR_LAT - 1)) state_nxt = READ;
            READ:    if (last_out) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Job configuration, fill/read counters and the read-return tracker.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            base_q    <= '0;
            len_q     <= '0;
            pass_m1_q <= '0;
            idx_q     <= '0;
            pass_q    <= '0;
            drain_q   <= '0;
            ridx_q    <= '0;
            oidx_q    <= '0;
            rd_done_q <= 1'b0;
            rd_pipe_q <= '0;
        end else begin
            rd_pipe_q <= RD_PIPE'({rd_pipe_q, rd_fire});
            unique case (state)
                IDLE: begin
                    if (start) begin
                        base_q    <= cfg_base;
                        len_q     <= cfg_len_m1;
                        pass_m1_q <= cfg_pass_m1;
                        idx_q     <= '0;
                        pass_q    <= '0;
                    end
                end
                FILL: begin
                    if (wr_fire) begin
                        if (idx_q == len_q) begin
                            idx_q  <= '0;
                            pass_q <= pass_q + 1'b1;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                    drain_q <= '0;
                end
                DRAIN: begin
                    drain_q   <= drain_q + 1'b1;
                    ridx_q    <= '0;
                    oidx_q    <= '0;
                    rd_done_q <= 1'b0;
                end
                READ: begin
                    if (rd_fire) begin
                        ridx_q <= ridx_q + 1'b1;
                        if (ridx_q == len_q) rd_done_q <= 1'b1;
                    end
                    if (out_fire) oidx_q <= oidx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    acc_seq_skid #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (SKID_DEPTH),
        .CNT_W (CNT_W)
    ) u_skid (
        .clk   (clk),
        .rstn  (rstn),
        .push  (rd_pipe_q[RD_PIPE-1]),
        .wdata (acc_rd_rdata),
        .pop   (out_fire),
        .rdata (skid_head),
        .count (skid_count),
        .empty (skid_empty)
    );

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Scoreboard bench for acc_seq_ctrl: accumulator RAM model, lane-sum reference, decoupled monitor.
module tb_acc_seq_ctrl;
    localparam int unsigned AW    = 9;
    localparam int unsigned DW    = 64;
    localparam int unsigned PW    = 8;
    localparam int unsigned MEM_N = 1 << AW;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic [AW-1:0] cfg_base, cfg_len_m1;
    logic [PW-1:0] cfg_pass_m1;
    logic          in_valid, in_ready;
    logic [DW-1:0] in_data;
    logic          acc_wr_en, acc_wr_we, acc_mode, acc_rd_en;
    logic [AW-1:0] acc_wr_addr, acc_rd_addr;
    logic [DW-1:0] acc_wr_wdata, acc_rd_rdata;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_data;
    logic          busy, done;

    acc_seq_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PASS_WIDTH(PW)) dut (
        .clk(clk), .rstn(rstn), .start(start),
        .cfg_base(cfg_base), .cfg_len_m1(cfg_len_m1), .cfg_pass_m1(cfg_pass_m1),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .acc_wr_en(acc_wr_en), .acc_wr_we(acc_wr_we), .acc_wr_addr(acc_wr_addr),
        .acc_wr_wdata(acc_wr_wdata), .acc_mode(acc_mode),
        .acc_rd_en(acc_rd_en), .acc_rd_addr(acc_rd_addr), .acc_rd_rdata(acc_rd_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    logic [75:0]   exp_wr[$];   // {en, we, mode, addr, data}
    logic [AW-1:0] exp_rd[$];
    logic [DW:0]   exp_out[$];  // {last, data}
    logic [DW-1:0] job_in[$];

    int rd_issued = 0, rd_popped = 0;
    int last_in_cyc = 0, done_cyc = 0;
    bit first_seen = 1'b1;
    int rdy_mode = 0, rdy_idx = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [DW-1:0] lane_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] r;
        for (int l = 0; l < DW / 16; l++) r[l*16 +: 16] = a[l*16 +: 16] + b[l*16 +: 16];
        return r;
    endfunction

    // Accumulator RAM: read data appears after the first edge and is sampled on the second.
    logic [DW-1:0] mem [MEM_N];
    logic [DW-1:0] rd_q;
    assign acc_rd_rdata = rd_q;
    always @(posedge clk) begin
        if (acc_rd_en) rd_q <= mem[acc_rd_addr];
        else           rd_q <= {$urandom, $urandom};
        if (acc_wr_en && acc_wr_we)
            mem[acc_wr_addr] <= acc_mode ? lane_add(mem[acc_wr_addr], acc_wr_wdata) : acc_wr_wdata;
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = (rdy_idx < 6) || (rdy_idx < 10 && rdy_idx % 2 == 0) || (rdy_idx >= 20);
        endcase
        rdy_idx++;
    end

    always @(negedge clk) begin : monitor
        logic [DW:0] e;
        if (rstn) begin
            if (acc_wr_en || acc_wr_we) begin
                if (exp_wr.size() == 0) chk("unexpected_write", {acc_wr_en, acc_wr_we, acc_wr_addr}, 0);
                else chk("write", {acc_wr_en, acc_wr_we, acc_mode, acc_wr_addr, acc_wr_wdata}, exp_wr.pop_front());
            end
            if (acc_rd_en) begin
                rd_issued++;
                chk("reads_outstanding_le_4", 1'(rd_issued - rd_popped <= 4), 1);
                if (exp_rd.size() == 0) chk("unexpected_read", {acc_rd_en, acc_rd_addr}, 0);
                else chk("read_addr", acc_rd_addr, exp_rd.pop_front());
            end
            if (out_valid && !first_seen) begin
                first_seen = 1'b1;
                chk("first_valid_latency", cyc - last_in_cyc, 7);
            end
            if (done) done_cyc = cyc;
            if (out_valid && out_ready) begin
                rd_popped++;
                if (exp_out.size() == 0) chk("unexpected_output", {out_valid, out_data}, 0);
                else begin
                    e = exp_out.pop_front();
                    chk("out_data", out_data, e[DW-1:0]);
                    chk("done_on_last", done, e[DW]);
                end
            end else if (done) begin
                chk("done_without_handshake", done, 0);
            end
        end
    end

    task automatic flush();
        exp_wr.delete(); exp_rd.delete(); exp_out.delete();
        rd_issued = 0; rd_popped = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctrl"}, {in_ready, out_valid, busy, done, acc_wr_en, acc_wr_we, acc_mode,
                            acc_rd_en, acc_wr_addr, acc_rd_addr}, 0);
        chk({tag, "_data"}, {acc_wr_wdata, out_data}, 0);
    endtask

    // Reference: word k's result is the lane-wise 16-bit sum of that word over all passes.
    task automatic prep_job(input int base, input int len_m1, input int pass_m1);
        int n = len_m1 + 1;
        logic [DW-1:0] sum;
        for (int p = 0; p <= pass_m1; p++)
            for (int k = 0; k < n; k++)
                exp_wr.push_back({1'b1, 1'b1, 1'(p != 0), AW'(base + k), job_in[p*n + k]});
        for (int k = 0; k < n; k++) begin
            exp_rd.push_back(AW'(base + k));
            sum = '0;
            for (int p = 0; p <= pass_m1; p++) sum = lane_add(sum, job_in[p*n + k]);
            exp_out.push_back({1'(k == len_m1), sum});
        end
    endtask

    task automatic pulse_start(input int base, input int len_m1, input int pass_m1);
        start = 1'b1; cfg_base = AW'(base); cfg_len_m1 = AW'(len_m1); cfg_pass_m1 = PW'(pass_m1);
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    // Feeds words with optional bubbles; start and cfg are scrambled to show they are ignored.
    task automatic feed(input int n_words, input bit valid_always);
        int k = 0;
        int budget = 0;
        while (k < n_words && budget < 4000) begin
            in_valid = valid_always ? 1'b1 : 1'($urandom_range(0, 3) != 0);
            in_data  = job_in[k];
            start    = 1'($urandom_range(0, 1));
            cfg_base = AW'($urandom); cfg_len_m1 = AW'($urandom); cfg_pass_m1 = PW'($urandom);
            @(negedge clk);
            chk("in_ready_in_fill", in_ready, 1);
            if (in_valid && in_ready) begin
                last_in_cyc = cyc;
                k++;
            end
            @(posedge clk); #1;
            budget++;
        end
        in_valid = 1'b0; start = 1'b0;
        if (k < n_words) chk("feed_timeout", k, n_words);
    endtask

    task automatic wait_done();
        int b = 0;
        while (exp_out.size() != 0 && b < 3000) begin
            @(posedge clk);
            b++;
        end
        #1;
        chk("job_complete_words_left", exp_out.size(), 0);
        chk("idle_after_job", {busy, out_valid, 1'(exp_wr.size() == 0), 1'(exp_rd.size() == 0)}, 4'b0011);
        flush();
    endtask

    task automatic run_job(input int base, input int len_m1, input int pass_m1,
                           input int ready_mode, input bit valid_always);
        first_seen = 1'b0;
        prep_job(base, len_m1, pass_m1);
        rdy_mode = (ready_mode == 2) ? 0 : ready_mode;
        pulse_start(base, len_m1, pass_m1);
        feed((len_m1 + 1) * (pass_m1 + 1), valid_always);
        if (ready_mode == 2) begin
            rdy_idx  = 0;
            rdy_mode = 2;
        end
        wait_done();
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic fill_random(input int n);
        job_in.delete();
        for (int i = 0; i < n; i++) job_in.push_back({$urandom, $urandom});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; start = 1'b0; cfg_base = '0; cfg_len_m1 = '0; cfg_pass_m1 = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        for (int i = 0; i < MEM_N; i++) mem[i] = {$urandom, $urandom};
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_state");
        rstn = 1'b1;
        @(posedge clk); #1;

        // Single pass, lanes 1..4, done latency from the last input.
        job_in.delete();
        for (int k = 0; k < 4; k++) job_in.push_back({4{16'(k + 1)}});
        run_job(0, 3, 0, 0, 1'b1);
        chk("done_latency", done_cyc - last_in_cyc, 10);

        // Three passes of 0x0003 per lane accumulate to 0x0009.
        job_in.delete();
        for (int k = 0; k < 6; k++) job_in.push_back(64'h0003_0003_0003_0003);
        run_job(5, 1, 2, 0, 1'b1);

        // Address wrap past the top of the accumulator.
        fill_random(8);
        run_job(510, 3, 1, 1, 1'b0);

        // Lane overflow wraps modulo 2^16.
        job_in.delete();
        for (int k = 0; k < 3; k++) job_in.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        for (int k = 0; k < 3; k++) job_in.push_back(64'h0002_0002_0002_0002);
        run_job(20, 2, 1, 0, 1'b1);

        // Output backpressure: toggling ready then a long stall.
        fill_random(32);
        run_job(100, 15, 1, 2, 1'b1);

        // Asynchronous reset during the third fill word abandons the job.
        fill_random(16);
        first_seen = 1'b1;
        prep_job(3, 7, 1);
        pulse_start(3, 7, 1);
        feed(2, 1'b1);
        in_valid = 1'b1; in_data = job_in[2];
        #2 rstn = 1'b0;
        #1 check_zero("reset_mid_fill");
        flush();
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;
        fill_random(10);
        run_job(7, 4, 1, 0, 1'b1);

        // Randomized jobs.
        for (int j = 0; j < 8; j++) begin
            int b, l, p;
            b = $urandom_range(0, MEM_N - 1);
            l = $urandom_range(0, 20);
            p = $urandom_range(0, 3);
            fill_random((l + 1) * (p + 1));
            run_job(b, l, p, 1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
